count_clusters_param: RTL and testbench

- Parametrised, pipelined population counter for VPF (valid-pattern-flag) vectors from the cluster-finding front end.
- Counts set bits in an arbitrary-width input. Produces a registered count, a valid flag and an overflow flag against a runtime threshold; count and overflow are aligned to the same cycle.
- Sits beside the cluster packer on clock4x and feeds cluster-multiplicity/overflow handling downstream.

---
 rtl/count_pkg.sv | 37 +++
 rtl/fast6count.sv | 26 ++
 rtl/count_clusters_param.sv | 144 ++++++++++++++
 tb/tb_count_clusters_param.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared sizing helpers for the VPF multiplicity counters: group size and
// the group/level/count-width derivations used by the population counters.
package count_pkg;

  localparam int GRP = 6;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int num_groups(input int w);
    return (w + GRP - 1) / GRP;
  endfunction

  function automatic int num_levels(input int w);
    return clog2(num_groups(w));
  endfunction

  function automatic int cnt_width(input int w);
    return clog2(w + 1);
  endfunction

  function automatic int level_nodes(input int w, input int k);
    return (num_groups(w) + (1 << k) - 1) >> k;
  endfunction

  // Leaf sums are 3 bits; each level adds a carry bit until the final count width.
  function automatic int level_width(input int w, input int k);
    int cap;
    cap = (cnt_width(w) > 3) ? cnt_width(w) : 3;
    return ((3 + k) < cap) ? (3 + k) : cap;
  endfunction

endpackage

// File: rtl/fast6count.sv
// Registered population count of one six-bit group (result 0..6).
module fast6count
  import count_pkg::*;
(
  input  logic           clk,
  input  logic [GRP-1:0] bits_i,
  output logic [2:0]     cnt_o
);

  logic [2:0] cnt_d;
  logic [2:0] cnt_q;

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < GRP; i++) begin
      cnt_d = cnt_d + {2'b00, bits_i[i]};
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/count_clusters_param.sv
// Pipelined VPF population counter with threshold overflow flag.
// Optional peak tracking is enabled with `define COUNT_CLUSTERS_PEAK_EN.
module count_clusters_param
  import count_pkg::*;
#(
  parameter int  WIDTH          = 1536,
  parameter int  DEFAULT_THRESH = 8,
  localparam int CNTW           = cnt_width(WIDTH)
) (
  input  logic             clock4x,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] vpfs_i,
  input  logic             valid_i,
  input  logic [CNTW-1:0]  thresh_i,
  output logic [CNTW-1:0]  cnt_o,
  output logic             valid_o,
  output logic             overflow_o,
  input  logic             peak_clr_i,
  output logic [CNTW-1:0]  peak_o
);

  localparam int G  = num_groups(WIDTH);
  localparam int L  = num_levels(WIDTH);
  localparam int RW = level_width(WIDTH, L);
  localparam int unused_default_thresh = DEFAULT_THRESH;

  logic [WIDTH-1:0] vpfs_d;
  logic [WIDTH-1:0] vpfs_q;
  logic [GRP*G-1:0] vpfs_pad;

  always_comb vpfs_d = vpfs_i;

  always_ff @(posedge clock4x) begin
    vpfs_q <= vpfs_d;
  end

  always_comb begin
    vpfs_pad = '0;
    vpfs_pad[WIDTH-1:0] = vpfs_q;
  end

  // Level 0 holds the group counts; each later level halves the node count.
  for (genvar gi = 0; gi <= L; gi++) begin : lvl
    localparam int N = level_nodes(WIDTH, gi);
    localparam int W = level_width(WIDTH, gi);
    logic [N*W-1:0] sum_flat;

    if (gi == 0) begin : leaf
      for (genvar ni = 0; ni < N; ni++) begin : grp
        fast6count u_cnt (
          .clk    (clock4x),
          .bits_i (vpfs_pad[ni*GRP +: GRP]),
          .cnt_o  (sum_flat[ni*W +: W])
        );
      end
    end else begin : add
      localparam int PN = level_nodes(WIDTH, gi - 1);
      localparam int PW = level_width(WIDTH, gi - 1);
      for (genvar ni = 0; ni < N; ni++) begin : node
        logic [W-1:0] sum_d;
        logic [W-1:0] sum_q;
        if (2 * ni + 1 < PN) begin : pair
          always_comb sum_d = W'(lvl[gi-1].sum_flat[(2*ni)*PW +: PW])
                            + W'(lvl[gi-1].sum_flat[(2*ni+1)*PW +: PW]);
        end else begin : pass
          always_comb sum_d = W'(lvl[gi-1].sum_flat[(2*ni)*PW +: PW]);
        end
        always_ff @(posedge clock4x) begin
          sum_q <= sum_d;
        end
        assign sum_flat[ni*W +: W] = sum_q;
      end
    end
  end

  logic [RW-1:0]   root;
  logic [CNTW-1:0] root_cnt;
  assign root     = lvl[L].sum_flat;
  assign root_cnt = CNTW'(root);

  logic [L+1:0]    vpipe_d, vpipe_q;
  logic [CNTW-1:0] cnt_d, cnt_q;
  logic            ovf_d, ovf_q;
  logic            valid_d, valid_q;

  // Output registers only load when the aligned valid bit arrives; otherwise hold.
  always_comb begin
    vpipe_d = {vpipe_q[L:0], valid_i};
    valid_d = vpipe_q[L+1];
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (vpipe_q[L+1]) begin
      cnt_d = root_cnt;
      ovf_d = (root_cnt > thresh_i);
    end
  end

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      vpipe_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      vpipe_q <= vpipe_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign overflow_o = ovf_q;
  assign valid_o    = valid_q;

`ifdef COUNT_CLUSTERS_PEAK_EN
  logic [CNTW-1:0] peak_d, peak_q;

  // A clear that coincides with a valid result restarts the peak at that result.
  always_comb begin
    peak_d = peak_q;
    if (peak_clr_i) begin
      peak_d = vpipe_q[L+1] ? root_cnt : '0;
    end else if (vpipe_q[L+1] && (root_cnt > peak_q)) begin
      peak_d = root_cnt;
    end
  end

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_o = peak_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr_i;
  assign peak_o          = '0;
`endif

endmodule

// File: tb/tb_count_clusters_param.sv
// Scoreboard bench for count_clusters_param: a 1536-bit and a 7-bit instance,
// expected popcounts queued at issue and checked by independent monitors.
module tb_count_clusters_param;

  localparam int LAT  = 10;
  localparam int LAT7 = 3;

  typedef struct {
    int          cnt;
    bit          ovf;
    int unsigned sedge;
  } exp_t;

  logic          clk;
  logic          reset_n;
  logic [1535:0] vpfs;
  logic          valid;
  logic [10:0]   thresh;
  logic [10:0]   cnt;
  logic          valid_o;
  logic          ovf;
  logic          peak_clr;
  logic [10:0]   peak;

  logic [6:0]    vpfs7;
  logic          valid7;
  logic [2:0]    thresh7;
  logic [2:0]    cnt7;
  logic          valid7_o;
  logic          ovf7;
  logic [2:0]    peak7;

  exp_t        q[$];
  exp_t        q7[$];
  int unsigned edge_cnt = 0;
  int          n_total  = 0;
  int          n_pass   = 0;
  bit          run7     = 0;

  count_clusters_param #(.WIDTH(1536), .DEFAULT_THRESH(8)) dut (
    .clock4x    (clk),
    .reset_n    (reset_n),
    .vpfs_i     (vpfs),
    .valid_i    (valid),
    .thresh_i   (thresh),
    .cnt_o      (cnt),
    .valid_o    (valid_o),
    .overflow_o (ovf),
    .peak_clr_i (peak_clr),
    .peak_o     (peak)
  );

  count_clusters_param #(.WIDTH(7), .DEFAULT_THRESH(3)) dut7 (
    .clock4x    (clk),
    .reset_n    (reset_n),
    .vpfs_i     (vpfs7),
    .valid_i    (valid7),
    .thresh_i   (thresh7),
    .cnt_o      (cnt7),
    .valid_o    (valid7_o),
    .overflow_o (ovf7),
    .peak_clr_i (1'b0),
    .peak_o     (peak7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, edge_cnt);
  endtask

  function automatic logic [1535:0] make_vec(input int k);
    logic [1535:0] v;
    v = '0;
    if (k >= 1536) return '1;
    if (k > 768) return ~make_vec(1536 - k);
    while ($countones(v) < k) v[$urandom_range(1535, 0)] = 1'b1;
    return v;
  endfunction

  task automatic drive(input logic [1535:0] vec, input bit v);
    exp_t e;
    @(negedge clk);
    vpfs  = vec;
    valid = v;
    if (v) begin
      e.cnt   = $countones(vec);
      e.ovf   = (e.cnt > int'(thresh));
      e.sedge = edge_cnt + 1;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
    end
  endtask

  function automatic logic [1535:0] rand_vec();
    logic [1535:0] v;
    v = '0;
    case ($urandom_range(0, 3))
      0: v = make_vec($urandom_range(0, 20));
      1: for (int i = 0; i < 48; i++) v[i*32 +: 32] = $urandom;
      2: v = '1;
      default: v = make_vec($urandom_range(0, 1536));
    endcase
    return v;
  endfunction

  // Monitor for the wide instance: valid timing, count, overflow, hold and peak.
  initial begin
    exp_t        e;
    bit          due;
    bit          clr_s;
    int unsigned last_cnt = 0;
    bit          last_ovf = 0;
    int unsigned mpeak = 0;
    forever begin
      @(posedge clk);
      clr_s = peak_clr;
      #1;
      if (!reset_n) begin
        last_cnt = 0; last_ovf = 0; mpeak = 0;
        continue;
      end
      while (q.size() > 0 && q[0].sedge + LAT < edge_cnt) begin
        n_total++;
        $display("FAIL latency: result sampled at edge %0d never appeared", q[0].sedge);
        void'(q.pop_front());
      end
      due = (q.size() > 0) && (q[0].sedge + LAT == edge_cnt);
      chk("valid_o", valid_o, due);
      if (due) begin
        e = q.pop_front();
        chk("cnt_o", cnt, e.cnt);
        chk("overflow_o", ovf, e.ovf);
        last_cnt = e.cnt;
        last_ovf = e.ovf;
        $display("w1536 edge %0d: cnt_o=%0d overflow_o=%0b expected %0d/%0b",
                 edge_cnt, cnt, ovf, e.cnt, e.ovf);
      end else begin
        chk("cnt_hold", cnt, last_cnt);
        chk("ovf_hold", ovf, last_ovf);
      end
`ifdef COUNT_CLUSTERS_PEAK_EN
      if (clr_s) mpeak = due ? e.cnt : 0;
      else if (due && e.cnt > mpeak) mpeak = e.cnt;
      chk("peak_o", peak, mpeak);
`else
      chk("peak_o", peak, 0);
`endif
    end
  end

  // Monitor for the 7-bit instance (three edges of latency).
  initial begin
    exp_t e;
    bit   due;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) continue;
      while (q7.size() > 0 && q7[0].sedge + LAT7 < edge_cnt) begin
        n_total++;
        $display("FAIL latency7: result sampled at edge %0d never appeared", q7[0].sedge);
        void'(q7.pop_front());
      end
      due = (q7.size() > 0) && (q7[0].sedge + LAT7 == edge_cnt);
      chk("valid7_o", valid7_o, due);
      if (due) begin
        e = q7.pop_front();
        chk("cnt7_o", cnt7, e.cnt);
        chk("overflow7_o", ovf7, e.ovf);
        $display("w7 edge %0d: cnt_o=%0d overflow_o=%0b expected %0d/%0b",
                 edge_cnt, cnt7, ovf7, e.cnt, e.ovf);
      end
    end
  end

  // Random stimulus for the 7-bit instance.
  initial begin
    exp_t e;
    wait (run7);
    while (run7) begin
      @(negedge clk);
      if (reset_n && $urandom_range(0, 2) != 0) begin
        vpfs7   = 7'($urandom);
        valid7  = 1'b1;
        e.cnt   = $countones(vpfs7);
        e.ovf   = (e.cnt > int'(thresh7));
        e.sedge = edge_cnt + 1;
        q7.push_back(e);
      end else begin
        valid7 = 1'b0;
      end
    end
    @(negedge clk);
    valid7 = 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    vpfs     = '0;
    valid    = 1'b0;
    thresh   = 11'd8;
    peak_clr = 1'b0;
    vpfs7    = '0;
    valid7   = 1'b0;
    thresh7  = 3'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("reset cnt_o", cnt, 0);
    chk("reset valid_o", valid_o, 0);
    chk("reset overflow_o", ovf, 0);
    chk("reset peak_o", peak, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run7 = 1;

    begin
      logic [1535:0] v;
      v = '0;
      v[0] = 1'b1; v[5] = 1'b1; v[6] = 1'b1; v[1535] = 1'b1;
      drive(v, 1);
    end
    idle(12);

    drive(make_vec(9), 1);
    drive(make_vec(8), 1);
    drive(make_vec(1536), 1);
    drive(make_vec(0), 1);
    drive(make_vec(3), 1);
    drive(make_vec($urandom_range(0, 1536)), 0);
    drive(make_vec(7), 1);
    idle(12);

    thresh = 11'd760;
    for (int i = 0; i < 150; i++) drive(rand_vec(), $urandom_range(0, 3) != 0);
    idle(12);

    thresh = 11'd2047;
    drive('1, 1);
    for (int i = 0; i < 40; i++) drive(rand_vec(), 1'b1);
    idle(12);
    thresh = 11'd0;
    drive(make_vec(1), 1);
    drive('0, 1);
    drive(make_vec(2), 1);
    idle(12);

    thresh = 11'd8;
    @(negedge clk); peak_clr = 1'b1; valid = 1'b0;
    @(negedge clk); peak_clr = 1'b0;
    drive(make_vec(5), 1);
    drive(make_vec(12), 1);
    drive(make_vec(3), 1);
    idle(12);
    drive(make_vec(4), 1);
    idle(9);
    @(negedge clk); peak_clr = 1'b1; valid = 1'b0;
    @(negedge clk); peak_clr = 1'b0;
    idle(12);

    for (int i = 0; i < 5; i++) drive(rand_vec(), 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset cnt_o", cnt, 0);
    chk("async reset valid_o", valid_o, 0);
    chk("async reset overflow_o", ovf, 0);
    chk("async reset peak_o", peak, 0);
    chk("async reset valid7_o", valid7_o, 0);
    chk("async reset cnt7_o", cnt7, 0);
    q.delete();
    q7.delete();
    valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(15);
    drive(make_vec(11), 1);
    idle(14);

    run7 = 0;
    idle(8);
    chk("drain wide", q.size(), 0);
    chk("drain narrow", q7.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
